sha1_msg_padder: RTL and testbench

Upstream feeder for the SHA-1 hardware engine. It accepts an arbitrary-length message as a stream of 32-bit big-endian words and emits the padded 512-bit blocks as a stream of 16 words each. Padding is the 0x80 marker, zero fill, and the 64-bit bit-length. The driver that loads the engine's data registers consumes this stream and starts one computation per block, loading the IV on the first block of a message.

---
 rtl/sha1_msg_padder.sv | 82 ++++++++
 tb/tb_sha1_msg_padder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder: turns a 32-bit word message stream into padded SHA-1 512-bit blocks of 16 words
module sha1_msg_padder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_index,
    output logic        out_first,
    output logic        out_msg_last,
    output logic        busy
);
    localparam logic [2:0] S_DATA   = 3'd0;
    localparam logic [2:0] S_MARK   = 3'd1;
    localparam logic [2:0] S_ZERO   = 3'd2;
    localparam logic [2:0] S_LEN_HI = 3'd3;
    localparam logic [2:0] S_LEN_LO = 3'd4;
    logic [2:0]  state, state_nx, mark_nx, nb;
    logic [3:0]  widx;
    logic [63:0] bitlen;
    logic        len_ok, first_pend, ld_en, acc, load, marker;
    logic [31:0] keep, word_nx;
    // next output word, next state and handshake decode
    always_comb begin
        ld_en    = !out_valid | out_ready;
        in_ready = reset_n && state == S_DATA && ld_en;
        acc      = in_valid && in_ready;
        load     = (state == S_DATA) ? acc : ld_en;
        nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        keep     = ~(32'hFFFF_FFFF >> {nb, 3'b000});
        marker   = (state == S_MARK) || (state == S_DATA && in_last && nb != 3'd4);
        mark_nx  = (widx == 4'd13) ? S_LEN_HI : S_ZERO;
        word_nx  = (state == S_DATA)   ? ((in_last && nb != 3'd4) ? ((in_data & keep) | (32'h8000_0000 >> {nb, 3'b000})) : in_data) :
                   (state == S_MARK)   ? 32'h8000_0000 :
                   (state == S_LEN_HI) ? bitlen[63:32] :
                   (state == S_LEN_LO) ? bitlen[31:0] : 32'h0;
        state_nx = (state == S_DATA)   ? (in_last ? ((nb == 3'd4) ? S_MARK : mark_nx) : S_DATA) :
                   (state == S_MARK)   ? mark_nx :
                   (state == S_ZERO)   ? ((widx == 4'd13 && len_ok) ? S_LEN_HI : S_ZERO) :
                   (state == S_LEN_HI) ? S_LEN_LO : S_DATA;
    end
    // output register, counters and message bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_DATA;
            widx         <= 4'd0;
            bitlen       <= 64'd0;
            len_ok       <= 1'b0;
            first_pend   <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_index    <= 4'd0;
            out_first    <= 1'b0;
            out_msg_last <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (load) begin
                out_valid    <= 1'b1;
                out_data     <= word_nx;
                out_index    <= widx;
                out_first    <= first_pend;
                out_msg_last <= state == S_LEN_LO;
                first_pend   <= state == S_LEN_LO;
                widx         <= widx + 4'd1;
                state        <= state_nx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // a marker at 14 leaves no room for the length; the wrap into the next block makes room
            if (load && marker) len_ok <= widx != 4'd14;
            else if (load && state == S_ZERO && widx == 4'd15) len_ok <= 1'b1;
            if (load && state == S_LEN_LO) bitlen <= 64'd0;
            else if (acc) bitlen <= bitlen + (in_last ? {58'd0, nb, 3'b000} : 64'd32);
            busy <= acc | (busy & !(out_valid & out_ready & out_msg_last));
        end
    end
endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder: randomized scoreboard bench against a byte-level SHA-1 padding model
module tb_sha1_msg_padder;
    logic        clk = 0, reset_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic [31:0] in_data = 0;
    logic [2:0]  in_nbytes = 0;
    logic        in_ready, out_valid, out_first, out_msg_last, busy;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    typedef logic [37:0] exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    bit   stall = 0, discard = 0;

    sha1_msg_padder dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_first(out_first), .out_msg_last(out_msg_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // reference: append 0x80, zero fill to 56 mod 64, then 64-bit big-endian bit length
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0] p[$];
        logic [63:0] bl;
        int nw;
        p = msg;
        bl = 64'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++)
            exp_q.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3], 4'(w % 16), w == 0, w == nw - 1});
    endtask

    task automatic drive(input logic [31:0] d, input logic l, input logic [2:0] n);
        int t = 0;
        in_valid = 1; in_data = d; in_last = l; in_nbytes = n;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++t > 500) begin
                $display("FAIL in_handshake_timeout");
                $fatal(1);
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
        if (t >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d words left, want 0", exp_q.size());
        end
        @(posedge clk);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("out_valid_idle", out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] msg[$], input bit junk);
        int nw, nb;
        logic [31:0] d;
        push_expected(msg);
        nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++)
                d[31-8*b -: 8] = (4*w + b < msg.size()) ? msg[4*w+b] : (junk ? 8'($urandom) : 8'h00);
            nb = (w == nw - 1) ? msg.size() - 4*w : int'($urandom % 8);
            if (w == nw - 1 && nb == 4 && junk) nb = $urandom_range(4, 7);
            drive(d, w == nw - 1, 3'(nb));
            if (w == 0) begin
                @(negedge clk);
                chk("busy_msg", busy, 1);
                @(posedge clk); #1;
            end
        end
        in_valid = 1; in_data = $urandom; in_last = 1'($urandom);
        repeat (2) begin
            @(negedge clk);
            chk("in_ready_pad", in_ready, 0);
        end
        in_valid = 0; in_last = 0;
        wait_done();
    endtask

    task automatic send_rand(input int len, input bit junk);
        logic [7:0] m[$];
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        send(m, junk);
    endtask

    // monitor: pops the scoreboard on every output handshake and checks stall stability
    initial begin
        bit held = 0;
        exp_t hv;
        forever begin
            @(negedge clk);
            if (!reset_n) held = 0;
            else begin
                if (held) chk("stall_hold", {out_valid, out_data, out_index, out_first, out_msg_last}, {1'b1, hv});
                held = out_valid && !out_ready;
                hv = {out_data, out_index, out_first, out_msg_last};
                if (out_valid && out_ready && !discard) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_word: got %0h want none", out_data);
                    end else chk("out_word", {out_data, out_index, out_first, out_msg_last}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = stall ? 1'($urandom) : 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] m[$];
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fields", {out_data, out_index, out_first, out_msg_last, busy}, 0);
        reset_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        send(m, 0);
        m = {};
        send(m, 0);
        send_rand(55, 0);
        send_rand(56, 0);
        send_rand(64, 0);
        stall = 1;
        send_rand(100, 1);
        for (int i = 0; i < 12; i++) begin
            stall = 1'($urandom);
            send_rand($urandom_range(0, 140), 1);
        end
        stall = 0;
        @(posedge clk); #1;
        discard = 1;
        for (int w = 0; w < 8; w++) drive($urandom, 0, 3'd0);
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_fields", {out_data, out_index, out_first, out_msg_last, busy}, 0);
        reset_n = 1;
        discard = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        send(m, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
